// File: rtl/pattern_det_pkg.sv
// Shared types and default sizing for the configurable serial pattern detector.
package pattern_det_pkg;

  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pattern_det_if.sv
// Bundle of the detector's host-side and stream-side signals for system/bench hookup.
interface pattern_det_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic clk
);
  logic             rst;
  logic             cfg_valid;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_target;
  logic             cfg_overlap;
  logic             cfg_ready;
  logic             start;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
endinterface

// File: rtl/pattern_shift_matcher.sv
// History shift register, fill counter and comparator; match_c flags a hit on the
// post-shift value so the controller can register it at the same edge.
module pattern_shift_matcher
  import pattern_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match_c
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Fill saturates at PAT_W so a match needs a full window of fresh bits.
  always_comb begin
    hist_d  = {hist_q[PAT_W-2:0], x};
    fill_d  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    match_c = shift && (fill_d == FILL_W'(PAT_W)) && (hist_d == pattern);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      hist_q <= hist_d;
      fill_q <= (match_c && !overlap) ? '0 : fill_d;
    end
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Run controller for the serial pattern detector: config capture, IDLE/RUN/DONE
// sequencing, saturating match counter and registered status outputs.
module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             cfg_overlap,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  ctrl_state_t      state_q;
  logic [PAT_W-1:0] pattern_q;
  logic [CNT_W-1:0] target_q;
  logic             overlap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             y_q, busy_q, done_q, ready_q;

  logic             launch_c, shift_c, match_c, hit_target_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Config beats start; abort suppresses both the shift and any match this cycle.
  always_comb begin
    launch_c     = ((state_q == IDLE) || (state_q == DONE)) && start && !cfg_valid;
    shift_c      = (state_q == RUN) && x_valid && !abort;
    cnt_inc_c    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    hit_target_c = (target_q != '0) && (cnt_inc_c == target_q);
  end

  pattern_shift_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch_c),
    .shift   (shift_c),
    .x       (x),
    .pattern (pattern_q),
    .overlap (overlap_q),
    .match_c (match_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      target_q  <= '0;
      overlap_q <= 1'b1;
      cnt_q     <= '0;
      y_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      y_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (cfg_valid) begin
            pattern_q <= cfg_pattern;
            target_q  <= cfg_target;
            overlap_q <= cfg_overlap;
          end else if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (match_c) begin
            y_q   <= 1'b1;
            cnt_q <= cnt_inc_c;
            if (hit_target_c) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign y         = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = ready_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed vector bench for pattern_det_ctrl: a per-cycle table of stimulus and
// expected outputs, plus a counter-saturation sequence.
module tb_pattern_det_ctrl;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic             rst;
    logic             cv;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] tgt;
    logic             ovl;
    logic             st;
    logic             ab;
    logic             xx;
    logic             xv;
    logic             ey;
    logic             eb;
    logic             ed;
    logic [CNT_W-1:0] ec;
  } vec_t;

  logic clk;
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  pattern_det_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus (.clk(clk));

  pattern_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (bus.clk),
    .rst         (bus.rst),
    .cfg_valid   (bus.cfg_valid),
    .cfg_pattern (bus.cfg_pattern),
    .cfg_target  (bus.cfg_target),
    .cfg_overlap (bus.cfg_overlap),
    .cfg_ready   (bus.cfg_ready),
    .start       (bus.start),
    .abort       (bus.abort),
    .x           (bus.x),
    .x_valid     (bus.x_valid),
    .y           (bus.y),
    .busy        (bus.busy),
    .done        (bus.done),
    .match_cnt   (bus.match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int r, input int cv, input int pat, input int tgt, input int ovl,
                     input int st, input int ab, input int xx, input int xv,
                     input int ey, input int eb, input int ed, input int ec);
    vec_t t;
    t.rst = 1'(r);   t.cv = 1'(cv);  t.pat = PAT_W'(pat); t.tgt = CNT_W'(tgt);
    t.ovl = 1'(ovl); t.st = 1'(st);  t.ab = 1'(ab);       t.xx = 1'(xx);
    t.xv  = 1'(xv);  t.ey = 1'(ey);  t.eb = 1'(eb);       t.ed = 1'(ed);
    t.ec  = CNT_W'(ec);
    vecs.push_back(t);
  endtask

  // Expected outputs after the edge: y, busy, done, match_cnt (cfg_ready = !busy).
  task automatic vrst();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic vcfg(input int pat, input int tgt, input int ovl, input int st,
                      input int ed, input int ec);
    add(0, 1, pat, tgt, ovl, st, 0, 0, 0, 0, 0, ed, ec);
  endtask
  task automatic vstart();
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic vbit(input int xx, input int xv, input int ab, input int ey,
                      input int eb, input int ed, input int ec);
    add(0, 0, 0, 0, 0, 0, ab, xx, xv, ey, eb, ed, ec);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    bus.rst         = t.rst;
    bus.cfg_valid   = t.cv;
    bus.cfg_pattern = t.pat;
    bus.cfg_target  = t.tgt;
    bus.cfg_overlap = t.ovl;
    bus.start       = t.st;
    bus.abort       = t.ab;
    bus.x           = t.xx;
    bus.x_valid     = t.xv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int idx, input vec_t t);
    check("y",         idx, 32'(bus.y),         32'(t.ey));
    check("busy",      idx, 32'(bus.busy),      32'(t.eb));
    check("done",      idx, 32'(bus.done),      32'(t.ed));
    check("cfg_ready", idx, 32'(bus.cfg_ready), 32'(!t.eb));
    check("match_cnt", idx, 32'(bus.match_cnt), 32'(t.ec));
  endtask

  initial begin
    bus.rst = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_target = '0;
    bus.cfg_overlap = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.x = 1'b0;
    bus.x_valid = 1'b0;

    // Reset, then overlapping 1011 over 1011011.
    vrst();
    vcfg('b1011, 0, 1, 0, 0, 0);
    vstart();
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(0, 1, 0, 0, 1, 0, 0);
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(1, 1, 0, 1, 1, 0, 1);
    vbit(0, 1, 0, 0, 1, 0, 1); vbit(1, 1, 0, 0, 1, 0, 1);
    vbit(1, 1, 0, 1, 1, 0, 2);
    vbit(0, 0, 1, 0, 0, 0, 2);
    // Non-overlapping: 1011011 gives one hit, then 1011 gives the second.
    vcfg('b1011, 0, 0, 0, 0, 2);
    vstart();
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(0, 1, 0, 0, 1, 0, 0);
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(1, 1, 0, 1, 1, 0, 1);
    vbit(0, 1, 0, 0, 1, 0, 1); vbit(1, 1, 0, 0, 1, 0, 1);
    vbit(1, 1, 0, 0, 1, 0, 1);
    vbit(1, 1, 0, 0, 1, 0, 1); vbit(0, 1, 0, 0, 1, 0, 1);
    vbit(1, 1, 0, 0, 1, 0, 1); vbit(1, 1, 0, 1, 1, 0, 2);
    vbit(0, 0, 1, 0, 0, 0, 2);
    // Target 2: done and y rise together, DONE ignores the stream, restart clears.
    vcfg('b1011, 2, 1, 0, 0, 2);
    vstart();
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(0, 1, 0, 0, 1, 0, 0);
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(1, 1, 0, 1, 1, 0, 1);
    vbit(0, 1, 0, 0, 1, 0, 1); vbit(1, 1, 0, 0, 1, 0, 1);
    vbit(1, 1, 0, 1, 0, 1, 2);
    vbit(1, 1, 0, 0, 0, 1, 2); vbit(0, 1, 0, 0, 0, 1, 2);
    vbit(1, 1, 0, 0, 0, 1, 2); vbit(1, 1, 0, 0, 0, 1, 2);
    vbit(0, 1, 1, 0, 0, 1, 2);
    vstart();
    vbit(0, 0, 1, 0, 0, 0, 0);
    // Gapped valid; idle-cycle x values would break the pattern if sampled.
    vcfg('b1011, 0, 1, 0, 0, 0);
    vstart();
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(1, 0, 0, 0, 1, 0, 0);
    vbit(0, 1, 0, 0, 1, 0, 0); vbit(0, 0, 0, 0, 1, 0, 0);
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(0, 0, 0, 0, 1, 0, 0);
    vbit(1, 1, 0, 1, 1, 0, 1); vbit(0, 0, 0, 0, 1, 0, 1);
    // Abort on the completing bit: no y, IDLE, count kept.
    vbit(0, 1, 0, 0, 1, 0, 1); vbit(1, 1, 0, 0, 1, 0, 1);
    vbit(1, 1, 1, 0, 0, 0, 1); vbit(0, 0, 0, 0, 0, 0, 1);
    // cfg_valid beats start; new pattern 0110 with target 1.
    vcfg('b0110, 1, 1, 1, 0, 1);
    vbit(0, 0, 0, 0, 0, 0, 1);
    vstart();
    vbit(0, 1, 0, 0, 1, 0, 0); vbit(1, 1, 0, 0, 1, 0, 0);
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(0, 1, 0, 1, 0, 1, 1);
    vcfg('b1011, 0, 1, 1, 1, 1);
    vstart();
    // Reset mid-run restores pattern 0000 / overlap on; no y until a new start.
    vbit(1, 1, 0, 0, 1, 0, 0); vbit(0, 1, 0, 0, 1, 0, 0);
    vbit(1, 1, 0, 0, 1, 0, 0);
    vrst();
    vbit(1, 1, 0, 0, 0, 0, 0);
    vstart();
    vbit(0, 1, 0, 0, 1, 0, 0); vbit(0, 1, 0, 0, 1, 0, 0);
    vbit(0, 1, 0, 0, 1, 0, 0); vbit(0, 1, 0, 1, 1, 0, 1);
    vbit(0, 1, 0, 1, 1, 0, 2);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_outs(i, vecs[i]);
    end

    // Counter saturation: every further 0 matches pattern 0000 with overlap.
    for (int k = 1; k <= 256; k++) begin
      vec_t t;
      int   exp_cnt;
      exp_cnt = (2 + k > 255) ? 255 : 2 + k;
      t = '{rst: 1'b0, cv: 1'b0, pat: '0, tgt: '0, ovl: 1'b0, st: 1'b0, ab: 1'b0,
            xx: 1'b0, xv: 1'b1, ey: 1'b1, eb: 1'b1, ed: 1'b0, ec: CNT_W'(exp_cnt)};
      drive(t);
      if (k >= 250) check_outs(1000 + k, t);
      else begin
        check("sat_y",   1000 + k, 32'(bus.y),         32'(1));
        check("sat_cnt", 1000 + k, 32'(bus.match_cnt), 32'(exp_cnt));
      end
    end
    begin
      vec_t t;
      t = '{rst: 1'b0, cv: 1'b0, pat: '0, tgt: '0, ovl: 1'b0, st: 1'b0, ab: 1'b1,
            xx: 1'b0, xv: 1'b1, ey: 1'b0, eb: 1'b0, ed: 1'b0, ec: CNT_W'(255)};
      drive(t);
      check_outs(2000, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_det_ctrl.md
Name: pattern_det_ctrl

Overview:
- Programmable serial pattern-detection controller for the team's bit-serial sequence-detection datapath.
- Accepts a configuration: pattern, match target and overlap mode.
- Sequences a detection run over a serial stream `x`, counts matches, pulses `y` on each match, and stops with `done` when the target is reached.
- Sits between a host/config agent and the serial stream source; generalises the fixed "1011" Moore detector into a configurable, controlled resource.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 8, width of match target and match counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- cfg_valid  input  1  load cfg_* fields this cycle (honoured only when cfg_ready=1).
- cfg_pattern  input  PAT_W  pattern; bit PAT_W-1 is the first bit received.
- cfg_target  input  CNT_W  matches before done; 0 = unlimited.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- cfg_ready  output  1  1 in IDLE and DONE.
- start  input  1  begin a run.
- abort  input  1  terminate a run.
- x  input  1  serial data bit.
- x_valid  input  1  `x` is valid this cycle.
- y  output  1  one-cycle match pulse (registered).
- busy  output  1  1 in RUN.
- done  output  1  1 in DONE (level).
- match_cnt  output  CNT_W  matches in current/last run; saturates at all-ones.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; y=0, busy=0, done=0, match_cnt=0, cfg_ready=1.
  - pattern=0, target=0, overlap=1, history=0, fill=0.
  - Reset mid-run abandons the run; no y or done is produced.
- States:
  - IDLE: cfg_valid loads config. Else start -> RUN, clearing history, fill and match_cnt.
  - RUN: on each cycle with x_valid=1, history <= {history[PAT_W-2:0], x} and fill <= min(fill+1, PAT_W). Cycles with x_valid=0 hold all state.
  - Match is evaluated on the post-shift value: fill reaches PAT_W and the new history equals pattern.
  - On a match at edge N:
    - y=1 for the cycle after edge N only.
    - match_cnt increments at edge N.
    - If overlap=0, fill is reset to 0 at edge N (history contents are don't-care).
    - If target!=0 and the new match_cnt equals target: state -> DONE at edge N, so done and y rise together.
  - abort in RUN -> IDLE; match_cnt is kept, done stays 0, no y for a bit sampled in the abort cycle. abort outside RUN is ignored.
  - DONE: x_valid is ignored and y=0. cfg_valid reloads config and stays in DONE. start -> RUN, clearing match_cnt, history and fill. abort is ignored.
- Priority in IDLE/DONE: cfg_valid beats start; start is ignored in a cycle where cfg_valid=1.
- cfg_valid outside IDLE/DONE is ignored; config is stable during RUN.
- start while in RUN is ignored. Priority in RUN: abort beats a match in the same cycle.
- match_cnt saturates at 2^CNT_W-1. With target=0 the run continues until abort.
- Latency: one cycle from the completing bit's sampling edge to y high.
- No combinational path from inputs to any output.

Decomposition:
- Package pattern_det_pkg holds:
  - state enum ctrl_state_t {IDLE, RUN, DONE}, 2-bit;
  - default PAT_W/CNT_W localparams.
- One sub-module, pattern_shift_matcher (PAT_W):
  - contains the history shift register, fill counter and comparator;
  - inputs: clk, rst, clear, shift, x, pattern, overlap;
  - output: match pulse.
- pattern_det_ctrl holds the FSM, config registers, counter and output registers.
- Connection to the bench is through an interface carrying clk, rst, x, y and the cfg/start/abort signals.

Test Plan:
- Overlap: pattern=1011, overlap=1, target=0, start; x_valid each cycle, stream 1,0,1,1,0,1,1 -> y pulses after bits 4 and 7; match_cnt=2; busy stays 1.
- Non-overlap: same stream, overlap=0 -> single y after bit 4; match_cnt=1. Then a further stream 1,0,1,1 -> second y; match_cnt=2.
- Target stop: target=2, overlap=1, stream 1011011 then 1011 -> done and y rise together after bit 7; busy=0; trailing bits produce no y; match_cnt stays 2. Then start -> match_cnt=0 and RUN.
- Gapped valid: stream 1,0,1,1 with x_valid=0 cycles interleaved between bits -> exactly one y, one cycle after the edge sampling the final 1.
- Abort/priority:
  - abort on the cycle the completing bit arrives -> no y; IDLE; match_cnt unchanged.
  - cfg_valid with start in IDLE -> config loaded, stays IDLE.
- Reset mid-run: rst after bits 1,0,1 -> all outputs 0 and IDLE next cycle. A following 1 produces no y until a new start.
